// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: credit-gated issue/retire controller around a fixed-latency FPU with an in-order result FIFO
// Ports: in_* request port (valid/ready, tag returned with result); fpu_a/fpu_b/fpu_op/fpu_rmode registered FPU drive;
// fpu_out/fpu_flags FPU return; out_* result port (valid/ready); flag_clr/sticky_flags accumulated exception flags,
// present only when FPU_ISSUE_STICKY_EN is defined (otherwise sticky_flags is tied to 0).
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int FPU_LAT = 4,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_a,
  input  logic [63:0]      in_b,
  input  logic [2:0]       in_op,
  input  logic [1:0]       in_rmode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [63:0]      fpu_a,
  output logic [63:0]      fpu_b,
  output logic [2:0]       fpu_op,
  output logic [1:0]       fpu_rmode,
  input  logic [63:0]      fpu_out,
  input  logic [7:0]       fpu_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [7:0]       out_flags,
  input  logic             flag_clr,
  output logic [7:0]       sticky_flags
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]        cnt_q, cnt_d, wp_q, rp_q;
  logic [FPU_LAT-1:0] trk_v_q, trk_v_d;
  logic [TAG_W-1:0]   trk_t_q [FPU_LAT];
  logic               cap_v_q;
  logic [63:0]        cap_res_q;
  logic [TAG_W-1:0]   cap_tag_q;
  logic [7:0]         cap_flg_q;
  logic [63:0]        res_m [DEPTH];
  logic [TAG_W-1:0]   tag_m [DEPTH];
  logic [7:0]         flg_m [DEPTH];
  logic               acc, pop, cap;
  // cnt counts tracker + capture stage + FIFO, so a capture always finds a free FIFO slot
  assign in_ready   = rst_n && (cnt_q < (AW+1)'(DEPTH));
  assign acc        = in_valid && in_ready;
  assign out_valid  = wp_q != rp_q;
  assign pop        = out_valid && out_ready;
  assign cap        = trk_v_q[FPU_LAT-1];
  assign out_result = out_valid ? res_m[rp_q[AW-1:0]] : '0;
  assign out_tag    = out_valid ? tag_m[rp_q[AW-1:0]] : '0;
  assign out_flags  = out_valid ? flg_m[rp_q[AW-1:0]] : '0;
  always_comb begin
    cnt_d   = cnt_q + (AW+1)'(acc) - (AW+1)'(pop);
    trk_v_d = FPU_LAT'({trk_v_q, acc});
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      trk_v_q   <= '0;
      cap_v_q   <= 1'b0;
      fpu_a     <= '0;
      fpu_b     <= '0;
      fpu_op    <= '0;
      fpu_rmode <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wp_q    <= wp_q + (AW+1)'(cap_v_q);
      rp_q    <= rp_q + (AW+1)'(pop);
      trk_v_q <= trk_v_d;
      cap_v_q <= cap;
      if (acc) begin
        fpu_a     <= in_a;
        fpu_b     <= in_b;
        fpu_op    <= in_op;
        fpu_rmode <= in_rmode;
      end
    end
  end
  // The capture stage delays FIFO entry by one cycle so results never fall through into out_*
  always_ff @(posedge clk) begin
    trk_t_q[0] <= in_tag;
    for (int i = FPU_LAT-1; i > 0; i--) trk_t_q[i] <= trk_t_q[i-1];
    if (cap) begin
      cap_res_q <= fpu_out;
      cap_tag_q <= trk_t_q[FPU_LAT-1];
      cap_flg_q <= fpu_flags;
    end
    if (cap_v_q) begin
      res_m[wp_q[AW-1:0]] <= cap_res_q;
      tag_m[wp_q[AW-1:0]] <= cap_tag_q;
      flg_m[wp_q[AW-1:0]] <= cap_flg_q;
    end
  end
`ifdef FPU_ISSUE_STICKY_EN
  logic [7:0] sticky_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= '0;
    else if (cap) sticky_q <= (flag_clr ? 8'h00 : sticky_q) | fpu_flags;
    else if (flag_clr) sticky_q <= '0;
  end
  assign sticky_flags = sticky_q;
`else
  logic unused_clr;
  assign unused_clr   = flag_clr;
  assign sticky_flags = '0;
`endif
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: randomized scenario bench for fpu_issue_ctrl with a queue-based reference model
module tb_fpu_issue_ctrl;
  localparam int DEPTH = 8;
  localparam int LAT = 4;
  localparam int TW = 5;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_ready, out_valid, out_ready = 0, flag_clr = 0;
  logic [63:0] in_a = 0, in_b = 0, fpu_a, fpu_b, fpu_out, out_result;
  logic [2:0] in_op = 0, fpu_op;
  logic [1:0] in_rmode = 0, fpu_rmode;
  logic [TW-1:0] in_tag = 0, out_tag;
  logic [7:0] fpu_flags, out_flags, sticky_flags;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  fpu_issue_ctrl #(.DEPTH(DEPTH), .FPU_LAT(LAT), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_rmode(in_rmode), .in_tag(in_tag), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
    .fpu_rmode(fpu_rmode), .fpu_out(fpu_out), .fpu_flags(fpu_flags), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags),
    .flag_clr(flag_clr), .sticky_flags(sticky_flags));
  // Model FPU: {flags, result}; flags are an arbitrary but deterministic function of the operands
  function automatic logic [71:0] fpu_fn(logic [63:0] a, logic [63:0] b, logic [2:0] op);
    logic [63:0] r;
    case (op)
      3'd0: r = $realtobits($bitstoreal(a) + $bitstoreal(b));
      3'd1: r = $realtobits($bitstoreal(a) - $bitstoreal(b));
      3'd2: r = $realtobits($bitstoreal(a) * $bitstoreal(b));
      default: r = a ^ b;
    endcase
    return {a[7:0] ^ b[7:0], r};
  endfunction
  // Un-reset FPU pipeline: output valid LAT edges after the operands were loaded
  logic [71:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= fpu_fn(fpu_a, fpu_b, fpu_op);
    for (int i = 1; i < LAT-1; i++) pipe[i] <= pipe[i-1];
  end
  assign fpu_out   = pipe[LAT-2][63:0];
  assign fpu_flags = pipe[LAT-2][71:64];
  // Reference model: every accepted op is an entry until popped; it is visible LAT+1 edges after acceptance
  typedef struct {logic [63:0] res; logic [TW-1:0] tag; logic [7:0] flg; int vis; int cap;} ent_t;
  ent_t q[$];
  int cyc = 0;
  logic [7:0] m_sticky = 0;
  logic [63:0] m_a = 0, m_b = 0;
  logic [2:0] m_op = 0;
  logic [1:0] m_rm = 0;
  function automatic bit m_ready();
    return rst_n === 1'b1 && q.size() < DEPTH;
  endfunction
  function automatic bit m_valid();
    return q.size() > 0 && cyc >= q[0].vis;
  endfunction
  always @(posedge clk or negedge rst_n) begin : model
    bit acc, pop, cv;
    logic [7:0] cf;
    logic [71:0] r;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      m_sticky = 0; m_a = 0; m_b = 0; m_op = 0; m_rm = 0;
    end else begin
      acc = in_valid && m_ready();
      pop = out_ready && m_valid();
      cyc++;
      if (pop) void'(q.pop_front());
      cv = 0; cf = 0;
      foreach (q[i]) if (q[i].cap == cyc) begin cv = 1; cf = q[i].flg; end
`ifdef FPU_ISSUE_STICKY_EN
      if (cv) m_sticky = (flag_clr ? 8'h00 : m_sticky) | cf;
      else if (flag_clr) m_sticky = 0;
`endif
      if (acc) begin
        r = fpu_fn(in_a, in_b, in_op);
        e.res = r[63:0]; e.flg = r[71:64]; e.tag = in_tag; e.vis = cyc + LAT + 1; e.cap = cyc + LAT;
        q.push_back(e);
        m_a = in_a; m_b = in_b; m_op = in_op; m_rm = in_rmode;
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction
  task automatic test_reset();
    logic [63:0] v [10];
    string nm [10];
    nm = '{"in_ready", "fpu_a", "fpu_b", "fpu_op", "fpu_rmode", "out_valid", "out_result", "out_tag", "out_flags", "sticky"};
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    v = '{64'(in_ready), fpu_a, fpu_b, 64'(fpu_op), 64'(fpu_rmode), 64'(out_valid), out_result,
          64'(out_tag), 64'(out_flags), 64'(sticky_flags)};
    foreach (v[i]) begin
      n_cmp++;
      if (v[i] !== 64'd0) begin n_err++; $display("FAIL reset_%s: got %h want 0", nm[i], v[i]); end
    end
    tick();
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    tick();
  endtask
  task automatic test_single();
    int k;
    out_ready = 1;
    in_valid = 1; in_a = 64'h3FF0000000000000; in_b = 64'h4000000000000000; in_op = 0; in_rmode = 0; in_tag = 3;
    tick();
    in_valid = 0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (out_valid) break;
      tick();
      k++;
    end
    n_cmp += 4;
    if (k != 5) begin n_err++; $display("FAIL single_latency: got %0d want 5", k); end
    if (out_result !== 64'h4008000000000000) begin n_err++; $display("FAIL single_result: got %h want 4008000000000000", out_result); end
    if (out_tag !== TW'(3)) begin n_err++; $display("FAIL single_tag: got %0d want 3", out_tag); end
    if (out_flags !== 8'h00) begin n_err++; $display("FAIL single_flags: got %h want 00", out_flags); end
    repeat (3) tick();
  endtask
  task automatic test_backpressure();
    int n;
    logic [63:0] hr;
    logic [TW-1:0] ht;
    out_ready = 0;
    n = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      in_valid = 1; in_a = r64(); in_b = r64(); in_op = 3'($urandom_range(0, 3)); in_rmode = 2'($urandom); in_tag = TW'(i);
      @(negedge clk);
      if (in_ready) n++;
      tick();
    end
    in_valid = 0;
    repeat (LAT + 3) tick();
    @(negedge clk);
    n_cmp += 2;
    if (n != DEPTH) begin n_err++; $display("FAIL bp_accepts: got %0d want %0d", n, DEPTH); end
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %b want 0", in_ready); end
    hr = out_result; ht = out_tag;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== hr || out_tag !== ht || out_tag !== TW'(0))
        begin n_err++; $display("FAIL bp_head_stable: got v=%b %h/%0d want 1 %h/%0d tag 0", out_valid, out_result, out_tag, hr, ht); end
    end
    tick();
    out_ready = 1;
    for (int j = 0; j < DEPTH; j++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || out_tag !== TW'(j) || q.size() == 0 || out_result !== q[0].res || out_flags !== q[0].flg)
        begin n_err++; $display("FAIL bp_drain_%0d: got v=%b tag=%0d res=%h", j, out_valid, out_tag, out_result); end
      tick();
    end
    @(negedge clk);
    n_cmp += 2;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", out_valid); end
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", in_ready); end
    tick();
  endtask
  task automatic test_back_to_back();
    int i, got, first, last, c;
    out_ready = 1;
    i = 0; got = 0; first = -1; last = -1; c = 0;
    while (got < 20 && c < 80) begin
      in_valid = i < 20; in_a = r64(); in_b = r64(); in_op = 3'($urandom_range(0, 3)); in_tag = TW'(i);
      @(negedge clk);
      if (i < 20) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready_%0d: got %b want 1", i, in_ready); end
        i++;
      end
      if (out_valid) begin
        n_cmp++;
        if (out_tag !== TW'(got) || q.size() == 0 || out_result !== q[0].res)
          begin n_err++; $display("FAIL stream_ret_%0d: got tag %0d res %h", got, out_tag, out_result); end
        if (first < 0) first = c;
        last = c;
        got++;
      end
      tick();
      c++;
    end
    in_valid = 0;
    n_cmp += 2;
    if (got != 20) begin n_err++; $display("FAIL stream_count: got %0d want 20", got); end
    if (last - first != 19) begin n_err++; $display("FAIL stream_gapless: got span %0d want 19", last - first); end
    repeat (3) tick();
  endtask
  task automatic test_sticky();
    logic [7:0] e1, e2;
`ifdef FPU_ISSUE_STICKY_EN
    e1 = 8'h88; e2 = 8'h10;
`else
    e1 = 8'h00; e2 = 8'h00;
`endif
    out_ready = 1; in_op = 3; in_b = 0; in_rmode = 0;
    flag_clr = 1; tick(); flag_clr = 0;
    in_valid = 1; in_a = 64'h80; in_tag = 1; tick();
    in_a = 64'h08; in_tag = 2; tick();
    in_valid = 0;
    repeat (8) tick();
    @(negedge clk);
    n_cmp++;
    if (sticky_flags !== e1) begin n_err++; $display("FAIL sticky_accum: got %h want %h", sticky_flags, e1); end
    tick();
    in_valid = 1; in_a = 64'h10; tick();
    in_valid = 0;
    repeat (3) tick();
    flag_clr = 1; tick(); flag_clr = 0;
    @(negedge clk);
    n_cmp++;
    if (sticky_flags !== e2) begin n_err++; $display("FAIL sticky_clr_cap: got %h want %h", sticky_flags, e2); end
    tick();
    flag_clr = 1; tick(); flag_clr = 0;
    @(negedge clk);
    n_cmp++;
    if (sticky_flags !== 8'h00) begin n_err++; $display("FAIL sticky_clr: got %h want 00", sticky_flags); end
    repeat (6) tick();
  endtask
  task automatic test_idle();
    logic [63:0] sa, sb;
    logic [2:0] so;
    logic [1:0] sr;
    int tg;
    in_valid = 1; in_a = r64(); in_b = r64(); in_op = 3'($urandom); in_rmode = 2'($urandom);
    sa = in_a; sb = in_b; so = in_op; sr = in_rmode;
    tick();
    in_valid = 0;
    @(negedge clk);
    n_cmp++;
    if (fpu_a !== sa || fpu_b !== sb || fpu_op !== so || fpu_rmode !== sr)
      begin n_err++; $display("FAIL idle_load: got %h %h %0d %0d want %h %h %0d %0d", fpu_a, fpu_b, fpu_op, fpu_rmode, sa, sb, so, sr); end
    tg = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      in_a = r64(); in_b = r64(); in_op = 3'($urandom); in_rmode = 2'($urandom);
      @(negedge clk);
      if (fpu_a !== sa || fpu_b !== sb || fpu_op !== so || fpu_rmode !== sr) tg++;
    end
    n_cmp++;
    if (tg != 0) begin n_err++; $display("FAIL idle_toggles: got %0d want 0", tg); end
    tick();
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom); out_ready = $urandom_range(0, 3) != 0; flag_clr = $urandom_range(0, 15) == 0;
      in_a = r64(); in_b = r64(); in_op = 3'($urandom); in_rmode = 2'($urandom); in_tag = TW'($urandom);
      @(negedge clk);
      n_cmp += 4;
      if (in_ready !== m_ready()) begin n_err++; $display("FAIL rnd_ready @%0d: got %b want %b", c, in_ready, m_ready()); end
      if (out_valid !== m_valid()) begin n_err++; $display("FAIL rnd_valid @%0d: got %b want %b", c, out_valid, m_valid()); end
      if (sticky_flags !== m_sticky) begin n_err++; $display("FAIL rnd_sticky @%0d: got %h want %h", c, sticky_flags, m_sticky); end
      if (fpu_a !== m_a || fpu_b !== m_b || fpu_op !== m_op || fpu_rmode !== m_rm)
        begin n_err++; $display("FAIL rnd_fpu_in @%0d: got %h %h want %h %h", c, fpu_a, fpu_b, m_a, m_b); end
      if (m_valid()) begin
        n_cmp++;
        if (out_result !== q[0].res || out_tag !== q[0].tag || out_flags !== q[0].flg)
          begin n_err++; $display("FAIL rnd_head @%0d: got %h/%0d/%h want %h/%0d/%h", c, out_result, out_tag, out_flags, q[0].res, q[0].tag, q[0].flg); end
      end
      tick();
    end
    in_valid = 0; flag_clr = 0; out_ready = 1;
    repeat (DEPTH + LAT + 4) tick();
  endtask
  task automatic test_reset_mid();
    logic [63:0] v [10];
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = r64(); in_b = r64(); in_op = 3'($urandom_range(0, 3)); in_tag = TW'(i);
      tick();
    end
    in_valid = 0;
    repeat (2) tick();
    rst_n = 0;
    @(negedge clk);
    v = '{64'(in_ready), fpu_a, fpu_b, 64'(fpu_op), 64'(fpu_rmode), 64'(out_valid), out_result,
          64'(out_tag), 64'(out_flags), 64'(sticky_flags)};
    foreach (v[i]) begin
      n_cmp++;
      if (v[i] !== 64'd0) begin n_err++; $display("FAIL midrst_out%0d: got %h want 0", i, v[i]); end
    end
    repeat (2) tick();
    rst_n = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        begin n_err++; $display("FAIL midrst_ghost_%0d: got valid=%b ready=%b want 0/1", i, out_valid, in_ready); end
      tick();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_sticky();
    test_idle();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fpu_issue_ctrl.md
# fpu_issue_ctrl

Issue/retire controller sitting directly upstream and downstream of the 64-bit `fpu` core. It accepts operation requests on a valid/ready port and drives the FPU operand, opcode and rounding-mode inputs. It tracks the FPU's fixed, non-stallable pipeline latency, captures each result and exception-flag set into a result FIFO, and returns it in order on a valid/ready port. Credit-based admission guarantees that the result FIFO never overflows.

## Interface
- `DEPTH`, 4: result FIFO entries; power of 2, ≥2; also the maximum number of outstanding operations.
- `FPU_LAT`, 4: cycles from operands presented at `fpu_*` to a valid `fpu_out`/flags; ≥1.
- `TAG_W`, 4: request tag width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when high together with `in_valid`.
- `in_a`, `in_b` in 64: IEEE-754 double operands.
- `in_op` in 3: FPU opcode.
- `in_rmode` in 2: rounding mode.
- `in_tag` in TAG_W: returned unchanged with the result.
- `fpu_a`, `fpu_b` out 64: registered operands to the FPU.
- `fpu_op` out 3: registered opcode to the FPU.
- `fpu_rmode` out 2: registered rounding mode to the FPU.
- `fpu_out` in 64: FPU result.
- `fpu_flags` in 8: FPU flags as {div_by_zero, zero, underflow, overflow, ine, qnan, snan, inf}, with bit 0 = inf.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_result` out 64: result data.
- `out_tag` out TAG_W: tag of the result.
- `out_flags` out 8: per-result flags, same bit order as `fpu_flags`.
- `flag_clr` in 1: clear the sticky flags.
- `sticky_flags` out 8: OR of the flags of every captured result since the last clear or reset.

## Operation
- **Credit counter.** `cnt` = in-flight operations + FIFO occupancy, range 0..DEPTH.
  - `in_ready = rst_n && (cnt < DEPTH)`. It is derived from registered state only; there is no combinational path from `out_ready`.
- **Accept.** On `in_valid && in_ready`:
  - `fpu_a`, `fpu_b`, `fpu_op` and `fpu_rmode` load the request.
  - A tracker shift register (FPU_LAT stages of {valid, tag}) enters valid=1 with `in_tag`.
  - `cnt` increments.
- **Idle.** With no accept, the `fpu_*` registers hold their previous values, so the FPU inputs do not toggle. The tracker enters valid=0.
- **Capture.** When the tracker's last stage is valid, {`fpu_out`, `fpu_flags`, tag} is written to the FIFO tail.
  - Capture cannot be refused: by the credit rule, the FIFO always has space.
- **Pop.** On `out_valid && out_ready`, the FIFO head is retired and `cnt` decrements.
  - If accept and pop occur in the same cycle, `cnt` is unchanged.
- **FIFO behaviour.**
  - Head data on `out_result`, `out_tag` and `out_flags` is held stable while `out_valid && !out_ready`.
  - Read and write pointers wrap modulo DEPTH.
  - Simultaneous capture and pop are legal at any occupancy, including full and empty.
  - Capture into an empty FIFO is not presented on `out_*` until the next cycle; there is no fall-through.
- **Ordering.** Results retire strictly in acceptance order.
- **Reset.** `rst_n` low, including mid-operation:
  - Tracker, FIFO and `cnt` are cleared, and all in-flight operations are discarded.
  - Late results emerging from the un-reset FPU are ignored, because every tracker stage is invalid.

## Timing
- **Reset values:**
  - `in_ready` 0 (1 in the first cycle after release)
  - `fpu_a`, `fpu_b` 0
  - `fpu_op` 0
  - `fpu_rmode` 0
  - `out_valid` 0
  - `out_result` 0
  - `out_tag` 0
  - `out_flags` 0
  - `sticky_flags` 0
- **Latency.** Accept at edge E0 leads to capture at edge E0+FPU_LAT and `out_valid` high after edge E0+FPU_LAT+1, given an empty FIFO. With FPU_LAT=4, latency is 5 cycles.
- **Throughput.** One operation per cycle while `out_ready` is high and DEPTH ≥ FPU_LAT+2.
- **Credit return.** A pop at edge E raises `in_ready` after E, never within the same cycle.

## Configuration
- **`FPU_ISSUE_STICKY_EN` defined:**
  - On each capture, `sticky_flags <= (flag_clr ? 0 : sticky_flags) | fpu_flags`.
  - When a clear coincides with a capture, the captured flags survive.
  - `flag_clr` with no capture zeroes the register on the next edge.
- **`FPU_ISSUE_STICKY_EN` undefined:**
  - `sticky_flags` is constant 0 and `flag_clr` is ignored.
  - No sticky register is synthesised.

## Test plan
- **Single op.** Reset, then accept a=1.0, b=2.0, op=0, tag=3 at E0; model FPU returns 3.0 with flags 0. Required: `out_valid` after E0+5, `out_result` = 0x4008000000000000, `out_tag` = 3.
- **Backpressure fill.** Hold `out_ready`=0 and offer 6 requests. Required: exactly 4 accepted, `in_ready` low afterwards, head stable. Release `out_ready` and require 4 results in order, then `in_ready` high again.
- **Streaming.** Hold `out_ready`=1 with DEPTH=8 and issue 20 back-to-back ops. Required: one accept per cycle and tags 0..19 retired in order with no gaps.
- **Sticky flags (`FPU_ISSUE_STICKY_EN`).**
  - A result with `fpu_flags`=0x80 (div_by_zero), followed by one with 0x08 (ine). Required: `sticky_flags` = 0x88.
  - `flag_clr` in the same cycle as a 0x10 capture. Required: `sticky_flags` = 0x10.
- **Reset mid-flight.** Accept 3 ops, then pulse `rst_n` low 2 cycles later. Required: all outputs return to their reset values, and no `out_valid` ever appears for the discarded ops, even though the model FPU still emits them.
- **Idle hold.** After one accept, hold `in_valid`=0 for 10 cycles. Required: `fpu_a`, `fpu_b`, `fpu_op` and `fpu_rmode` show zero toggles.
